// File: rtl/minhash_sketch_engine_pkg.sv
// proj_pkg: constants and FSM state type shared by minhash_sketch_engine and its lanes
package proj_pkg;
    localparam int BASE_LEN = 2;
    localparam logic [15:0] MULT = 16'h9E37;
    localparam logic [15:0] SEED [4] = '{16'h0000, 16'h5A5A, 16'hC3C3, 16'h1234};
    typedef enum logic [1:0] {FILL, ACCUM, DRAIN, EMIT} state_t;
endpackage

// File: rtl/minhash_sketch_engine_lane.sv
// minhash_lane: one seeded multiplicative hash lane and its running minimum
module minhash_lane
    import proj_pkg::*;
#(
    parameter int KW = 16,
    parameter int HASH_W = 16,
    parameter logic [HASH_W-1:0] SEED_V = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [KW-1:0]     kmer,
    output logic [HASH_W-1:0] min_val
);
    logic [HASH_W-1:0] hash;
    assign hash = (HASH_W'(kmer) ^ SEED_V) * HASH_W'(MULT);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) min_val <= '1;
        else if (clear) min_val <= '1;
        else if (en && hash < min_val) min_val <= hash;
endmodule

// File: rtl/minhash_sketch_engine.sv
// minhash_sketch_engine: streaming k-mer MinHash signature, one signature per DNA fragment.
// Define MINHASH_CANON_EN to hash canonical k-mers (smaller of forward and reverse complement).
module minhash_sketch_engine
    import proj_pkg::*;
#(
    parameter int K = 8,
    parameter int NUM_HASH = 4,
    parameter int HASH_W = 16,
    parameter int FRAG_BASES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [BASE_LEN-1:0]        in_base,
    input  logic                       in_last,
    output logic                       out_wait,
    output logic                       sig_valid,
    input  logic                       sig_ready,
    output logic [NUM_HASH*HASH_W-1:0] sig_data,
    output logic                       sig_empty
);
    localparam int KW = K * BASE_LEN;
    localparam int CW = $clog2(FRAG_BASES + 1);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [KW-1:0] fwd, hash_kmer;
    logic kvalid, accept, frag_end, done;
    assign out_wait  = state == DRAIN || state == EMIT;
    assign sig_valid = state == EMIT;
    assign sig_empty = state == EMIT && cnt < CW'(K);
    assign accept    = in_valid && !out_wait;
    assign frag_end  = accept && (in_last || cnt == CW'(FRAG_BASES - 1));
    assign done      = sig_valid && sig_ready;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= FILL;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            FILL:    state_nx = frag_end ? DRAIN : (accept && cnt == CW'(K - 2)) ? ACCUM : FILL;
            ACCUM:   state_nx = frag_end ? DRAIN : ACCUM;
            DRAIN:   state_nx = EMIT;
            default: state_nx = done ? FILL : EMIT;
        endcase
    end
    // kvalid marks the k-mer just shifted in; lanes fold it in on the following edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt    <= '0;
            fwd    <= '0;
            kvalid <= 1'b0;
        end else if (done) begin
            cnt    <= '0;
            fwd    <= '0;
            kvalid <= 1'b0;
        end else begin
            kvalid <= accept && cnt >= CW'(K - 1);
            if (accept) begin
                cnt <= cnt + 1'b1;
                fwd <= {fwd[KW-BASE_LEN-1:0], in_base};
            end
        end
`ifdef MINHASH_CANON_EN
    logic [KW-1:0] rc;
    // bitwise inversion of a 2-bit code is its complement 3-b
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rc <= '0;
        else if (done) rc <= '0;
        else if (accept) rc <= {~in_base, rc[KW-1:BASE_LEN]};
    assign hash_kmer = fwd < rc ? fwd : rc;
`else
    assign hash_kmer = fwd;
`endif
    for (genvar i = 0; i < NUM_HASH; i++) begin : g_lane
        minhash_lane #(
            .KW(KW),
            .HASH_W(HASH_W),
            .SEED_V(HASH_W'(SEED[i % 4]))
        ) u_lane (
            .clk(clk),
            .rst_n(rst_n),
            .clear(done),
            .en(kvalid),
            .kmer(hash_kmer),
            .min_val(sig_data[i*HASH_W +: HASH_W])
        );
    end
endmodule

// File: tb/tb_minhash_sketch_engine.sv
// tb_minhash_sketch_engine: scoreboard bench for minhash_sketch_engine (default parameters).
module tb_minhash_sketch_engine;
    localparam int K = 8, NH = 4, HW = 16, KW = 16;
    localparam logic [15:0] TSEED [4] = '{16'h0000, 16'h5A5A, 16'hC3C3, 16'h1234};
    logic clk = 0, rst_n = 1, in_valid = 0, in_last = 0, sig_ready = 0;
    logic [1:0] in_base = 0;
    logic out_wait, sig_valid, sig_empty;
    logic [NH*HW-1:0] sig_data;
    int n_cmp = 0, n_bad = 0;
    logic [1:0] frag [64];
    logic [NH*HW-1:0] exp_data_q [$];
    logic exp_empty_q [$];
    logic [NH*HW-1:0] ed;
    logic ee;

    minhash_sketch_engine dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_base(in_base),
        .in_last(in_last), .out_wait(out_wait), .sig_valid(sig_valid),
        .sig_ready(sig_ready), .sig_data(sig_data), .sig_empty(sig_empty)
    );

    always #5 clk = ~clk;

    function automatic logic [NH*HW-1:0] model(input int n);
        logic [KW-1:0] f = '0, r = '0, c;
        logic [HW-1:0] h;
        logic [NH*HW-1:0] res = '1;
        for (int j = 0; j < n; j++) begin
            f = {f[KW-3:0], frag[j]};
            r = {2'd3 - frag[j], r[KW-1:2]};
            c = f;
`ifdef MINHASH_CANON_EN
            if (r < f) c = r;
`endif
            if (j >= K - 1)
                for (int i = 0; i < NH; i++) begin
                    h = (c ^ TSEED[i]) * 16'h9E37;
                    if (h < res[i*HW +: HW]) res[i*HW +: HW] = h;
                end
        end
        return res;
    endfunction

    task automatic fill_const(input int n, input logic [1:0] v);
        for (int j = 0; j < n; j++) frag[j] = v;
    endtask

    task automatic fill_rand(input int n);
        for (int j = 0; j < n; j++) frag[j] = 2'($urandom_range(0, 3));
    endtask

    task automatic send_frag(input int n, input bit last);
        for (int j = 0; j < n; j++) begin
            in_valid = 1; in_base = frag[j]; in_last = last && j == n - 1;
            @(posedge clk); #1;
        end
        in_valid = 0; in_last = 0;
        exp_data_q.push_back(model(n));
        exp_empty_q.push_back(n < K);
    endtask

    task automatic await_sig(output bit ok);
        int t = 0;
        while (!sig_valid && t < 8) begin @(posedge clk); #1; t++; end
        ok = sig_valid;
        ed = exp_data_q.pop_front();
        ee = exp_empty_q.pop_front();
    endtask

    task automatic handshake;
        sig_ready = 1; @(posedge clk); #1; sig_ready = 0;
    endtask

    task automatic test_reset;
        @(posedge clk); #3 rst_n = 0; #1;
        n_cmp++; if (out_wait !== 1'b0) begin n_bad++; $display("FAIL reset_out_wait: got %b expected 0", out_wait); end
        n_cmp++; if (sig_valid !== 1'b0) begin n_bad++; $display("FAIL reset_sig_valid: got %b expected 0", sig_valid); end
        n_cmp++; if (sig_empty !== 1'b0) begin n_bad++; $display("FAIL reset_sig_empty: got %b expected 0", sig_empty); end
        n_cmp++; if (sig_data !== {NH{16'hFFFF}}) begin n_bad++; $display("FAIL reset_sig_data: got %h expected all ones", sig_data); end
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_short;
        bit ok;
        fill_rand(7);
        send_frag(7, 1);
        n_cmp++; if (out_wait !== 1'b1 || sig_valid !== 1'b0) begin n_bad++; $display("FAIL short_drain: got wait=%b valid=%b expected wait=1 valid=0", out_wait, sig_valid); end
        @(posedge clk); #1;
        n_cmp++; if (sig_valid !== 1'b1) begin n_bad++; $display("FAIL short_latency: got sig_valid=%b expected 1", sig_valid); end
        await_sig(ok);
        n_cmp++; if (sig_empty !== ee || sig_empty !== 1'b1) begin n_bad++; $display("FAIL short_empty: got %b expected 1", sig_empty); end
        n_cmp++; if (sig_data !== ed) begin n_bad++; $display("FAIL short_data: got %h expected %h", sig_data, ed); end
        handshake();
    endtask

    task automatic test_all_a;
        bit ok;
        logic [15:0] l1;
        l1 = 16'h5A5A * 16'h9E37;
        fill_const(64, 2'd0);
        send_frag(64, 0);
        in_valid = 1; in_base = 2'd3;
        n_cmp++; if (out_wait !== 1'b1) begin n_bad++; $display("FAIL alla_holdoff: got out_wait=%b expected 1", out_wait); end
        await_sig(ok);
        in_valid = 0;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL alla_timeout: got sig_valid=0 expected 1"); end
        n_cmp++; if (sig_data !== ed) begin n_bad++; $display("FAIL alla_data: got %h expected %h", sig_data, ed); end
        n_cmp++; if (sig_data[15:0] !== 16'h0000 || sig_data[31:16] !== l1) begin n_bad++; $display("FAIL alla_lanes: got lane0=%h lane1=%h expected 0000 %h", sig_data[15:0], sig_data[31:16], l1); end
        n_cmp++; if (sig_empty !== 1'b0) begin n_bad++; $display("FAIL alla_empty: got %b expected 0", sig_empty); end
        handshake();
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [NH*HW-1:0] held;
        fill_rand(20);
        send_frag(20, 1);
        await_sig(ok);
        held = sig_data;
        n_cmp++; if (!ok || sig_data !== ed) begin n_bad++; $display("FAIL bp_data: got %h expected %h", sig_data, ed); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1; in_base = 2'($urandom_range(0, 3)); in_last = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n_cmp++; if (sig_valid !== 1'b1 || out_wait !== 1'b1 || sig_data !== held) begin n_bad++; $display("FAIL bp_hold: got valid=%b wait=%b data=%h expected 1 1 %h", sig_valid, out_wait, sig_data, held); end
        end
        in_valid = 0; in_last = 0;
        handshake();
        n_cmp++; if (sig_valid !== 1'b0 || out_wait !== 1'b0) begin n_bad++; $display("FAIL bp_release: got valid=%b wait=%b expected 0 0", sig_valid, out_wait); end
        fill_rand(12);
        send_frag(12, 1);
        await_sig(ok);
        n_cmp++; if (!ok || sig_data !== ed || sig_empty !== ee) begin n_bad++; $display("FAIL bp_next: got %h/%b expected %h/%b", sig_data, sig_empty, ed, ee); end
        handshake();
    endtask

    task automatic test_reset_mid;
        bit ok, seen = 0;
        fill_rand(30);
        for (int j = 0; j < 30; j++) begin
            in_valid = 1; in_base = frag[j]; @(posedge clk); #1;
        end
        in_valid = 0;
        #3 rst_n = 0; #1;
        n_cmp++; if (sig_valid !== 1'b0 || out_wait !== 1'b0 || sig_data !== {NH{16'hFFFF}}) begin n_bad++; $display("FAIL mid_reset: got valid=%b wait=%b data=%h expected 0 0 all ones", sig_valid, out_wait, sig_data); end
        @(posedge clk); #1 rst_n = 1;
        for (int c = 0; c < 4; c++) begin @(posedge clk); #1; if (sig_valid) seen = 1; end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL mid_no_emit: got sig_valid=1 expected 0"); end
        fill_rand(64);
        send_frag(64, 0);
        await_sig(ok);
        n_cmp++; if (!ok || sig_data !== ed || sig_empty !== ee) begin n_bad++; $display("FAIL mid_after: got %h/%b expected %h/%b", sig_data, sig_empty, ed, ee); end
        handshake();
    endtask

    task automatic test_canon;
        bit ok;
        logic [NH*HW-1:0] a, t;
        fill_const(10, 2'd0);
        send_frag(10, 1);
        await_sig(ok);
        a = sig_data;
        n_cmp++; if (!ok || sig_data !== ed) begin n_bad++; $display("FAIL canon_a: got %h expected %h", sig_data, ed); end
        handshake();
        fill_const(10, 2'd3);
        send_frag(10, 1);
        await_sig(ok);
        t = sig_data;
        n_cmp++; if (!ok || sig_data !== ed) begin n_bad++; $display("FAIL canon_t: got %h expected %h", sig_data, ed); end
        handshake();
`ifdef MINHASH_CANON_EN
        n_cmp++; if (a !== t) begin n_bad++; $display("FAIL canon_equal: got A=%h T=%h expected equal", a, t); end
`else
        n_cmp++; if (a === t) begin n_bad++; $display("FAIL canon_differ: got A=%h T=%h expected different", a, t); end
`endif
    endtask

    initial begin
        test_reset();
        test_short();
        test_all_a();
        test_backpressure();
        test_reset_mid();
        test_canon();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
